// File: rtl/ipsxe_floating_point_one_loc_pipe_v1_0_if.sv
// Operand/result bundle for the pipelined one-locator.
// The master drives the sample side; the slave (the locator) drives the results.
interface ipsxe_floating_point_one_loc_pipe_v1_0_if #(
    parameter int WIDTH = 16
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             i_valid;
    logic             i_mode;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic [LOG2W-1:0] o_one_location;
    logic             o_zero;
    logic [WIDTH-1:0] o_norm_data;

    modport master (
        output i_valid, i_mode, i_data,
        input  o_valid, o_one_location, o_zero, o_norm_data
    );

    modport slave (
        input  i_valid, i_mode, i_data,
        output o_valid, o_one_location, o_zero, o_norm_data
    );
endinterface

// File: rtl/ipsxe_floating_point_one_loc_pipe_v1_0.sv
// Pipelined leading/trailing-one locator with normaliser.
// A LOG2W-level binary search tree, registered every LEVELS_PER_STAGE levels,
// followed by one normalise register. The bus interface WIDTH must match WIDTH here.
module ipsxe_floating_point_one_loc_pipe_v1_0 #(
    parameter int WIDTH            = 16,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_aclken,
    ipsxe_floating_point_one_loc_pipe_v1_0_if.slave bus
);
    localparam int LOG2W    = $clog2(WIDTH);
    localparam int N_STAGES = (LOG2W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
    localparam int LAT      = N_STAGES + 1;

    // Everything that travels down the search pipeline with one sample.
    typedef struct packed {
        logic [LOG2W-1:0] loc;   // location bits resolved so far (MSB first)
        logic [WIDTH-1:0] win;   // remaining search window, LSB-aligned
        logic [WIDTH-1:0] data;  // original, un-reversed operand
        logic             mode;  // 0 = leading one, 1 = trailing one
    } stage_t;

    stage_t entry;

    // Trailing-one search is a leading-one search on the bit-reversed word.
    // NOTE: always_comb uses blocking '=' and assigns every output first, so no latch is inferred.
    always_comb begin
        entry      = '0;
        entry.data = bus.i_data;
        entry.mode = bus.i_mode;
        for (int i = 0; i < WIDTH; i++) begin
            entry.win[i] = bus.i_mode ? bus.i_data[WIDTH-1-i] : bus.i_data[i];
        end
    end

    for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
        localparam int K_HI = LOG2W - 1 - s * LEVELS_PER_STAGE;
        localparam int K_LO = (K_HI - LEVELS_PER_STAGE + 1 > 0) ? K_HI - LEVELS_PER_STAGE + 1 : 0;

        stage_t           cur;
        stage_t           nxt;
        stage_t           q;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] upper;

        if (s == 0) begin : g_first
            assign cur = entry;
        end else begin : g_next
            assign cur = g_stage[s-1].q;
        end

        // Tree levels K_HI..K_LO: location bit = OR of upper half; keep the half holding the one.
        always_comb begin
            nxt   = cur;
            mask  = '0;
            upper = '0;
            for (int k = K_HI; k >= K_LO; k--) begin
                mask       = ~({WIDTH{1'b1}} << (1 << k));
                upper      = (nxt.win >> (1 << k)) & mask;
                nxt.loc[k] = |upper;
                nxt.win    = (|upper) ? upper : (nxt.win & mask);
            end
        end

        // Stage register; loads on every enabled cycle regardless of valid.
        // NOTE: pipeline state is registered with non-blocking '<=' and fully reset so a
        // reset discards every in-flight sample rather than leaving stale data behind.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                q <= '0;
            end else if (i_aclken) begin
                q <= nxt;
            end
        end
    end

    stage_t           last;
    logic             search_zero;
    logic [LOG2W-1:0] loc_fix;
    logic [WIDTH-1:0] norm_fix;
    logic [LAT-1:0]   vld_q;
    logic [LOG2W-1:0] loc_q;
    logic             zero_q;
    logic [WIDTH-1:0] norm_q;

    assign last = g_stage[N_STAGES-1].q;

    // Location fix-up and shift. With WIDTH a power of two, WIDTH-1-j is just ~j, so the
    // reversed-word index maps back to the original index (and the left-shift amount)
    // by inversion alone.
    always_comb begin
        search_zero = ~(|last.win) & ~(|last.loc);
        loc_fix     = last.mode ? ~last.loc : last.loc;
        norm_fix    = last.mode ? (last.data >> loc_fix) : (last.data << ~loc_fix);
        if (search_zero) begin
            loc_fix  = '0;
            norm_fix = '0;
        end
    end

    // Normalise register and LAT-deep valid shift, frozen together by the clock enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q  <= '0;
            loc_q  <= '0;
            zero_q <= 1'b0;
            norm_q <= '0;
        end else if (i_aclken) begin
            vld_q  <= {vld_q[LAT-2:0], bus.i_valid};
            loc_q  <= loc_fix;
            zero_q <= search_zero;
            norm_q <= norm_fix;
        end
    end

    assign bus.o_valid        = vld_q[LAT-1];
    assign bus.o_one_location = loc_q;
    assign bus.o_zero         = zero_q;
    assign bus.o_norm_data    = norm_q;
endmodule

// File: tb/tb_ipsxe_floating_point_one_loc_pipe_v1_0.sv
// Directed and sweep bench for the pipelined one-locator in three configurations:
// 16/2 (LAT 3), 8/1 (LAT 4) and 64/6 (LAT 2).
module tb_ipsxe_floating_point_one_loc_pipe_v1_0;
    logic clk = 1'b0;
    logic rst_n;
    logic aclken;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] d;
        logic        m;
    } smp_t;

    smp_t q8[$];
    smp_t q64[$];

    always #5 clk = ~clk;

    ipsxe_floating_point_one_loc_pipe_v1_0_if #(.WIDTH(16)) bus16 ();
    ipsxe_floating_point_one_loc_pipe_v1_0_if #(.WIDTH(8))  bus8  ();
    ipsxe_floating_point_one_loc_pipe_v1_0_if #(.WIDTH(64)) bus64 ();

    ipsxe_floating_point_one_loc_pipe_v1_0 #(.WIDTH(16), .LEVELS_PER_STAGE(2)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_aclken(aclken), .bus(bus16));
    ipsxe_floating_point_one_loc_pipe_v1_0 #(.WIDTH(8), .LEVELS_PER_STAGE(1)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_aclken(aclken), .bus(bus8));
    ipsxe_floating_point_one_loc_pipe_v1_0 #(.WIDTH(64), .LEVELS_PER_STAGE(6)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_aclken(aclken), .bus(bus64));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic v, input logic m, input logic [15:0] d);
        bus16.i_valid = v;
        bus16.i_mode  = m;
        bus16.i_data  = d;
    endtask

    task automatic expect16(input string tag, input logic [3:0] loc, input logic z, input logic [15:0] norm);
        check({tag, "_valid"}, 64'(bus16.o_valid), 64'd1);
        check({tag, "_loc"}, 64'(bus16.o_one_location), 64'(loc));
        check({tag, "_zero"}, 64'(bus16.o_zero), 64'(z));
        check({tag, "_norm"}, 64'(bus16.o_norm_data), 64'(norm));
    endtask

    // Straightforward bit-scan reference, independent of any tree structure.
    function automatic void model(input logic [63:0] d, input logic m, input int w,
                                  output logic [63:0] loc, output logic z, output logic [63:0] norm);
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        loc  = '0;
        z    = (d == '0);
        norm = '0;
        if (!z) begin
            if (!m) begin
                for (int i = 0; i < w; i++) if (d[i]) loc = 64'(i);
                norm = (d << (w - 1 - int'(loc))) & mask;
            end else begin
                for (int i = w - 1; i >= 0; i--) if (d[i]) loc = 64'(i);
                norm = d >> loc;
            end
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] eloc;
        logic [63:0] enorm;
        logic        ez;
        logic [63:0] rd;
        logic        rm;
        smp_t        s;
        int          vcount;

        rst_n  = 1'b0;
        aclken = 1'b1;
        drive16(1'b0, 1'b0, 16'h0000);
        bus8.i_valid  = 1'b0; bus8.i_mode  = 1'b0; bus8.i_data  = '0;
        bus64.i_valid = 1'b0; bus64.i_mode = 1'b0; bus64.i_data = '0;

        // Reset state
        #3;
        check("rst_valid16", 64'(bus16.o_valid), 64'd0);
        check("rst_loc16",   64'(bus16.o_one_location), 64'd0);
        check("rst_zero16",  64'(bus16.o_zero), 64'd0);
        check("rst_norm16",  64'(bus16.o_norm_data), 64'd0);
        check("rst_valid8",  64'(bus8.o_valid), 64'd0);
        check("rst_valid64", 64'(bus64.o_valid), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Leading one, single pulse, exact latency 3
        drive16(1'b1, 1'b0, 16'h0100);
        step();
        drive16(1'b0, 1'b0, 16'h0000);
        step();
        check("t1_early_valid", 64'(bus16.o_valid), 64'd0);
        step();
        expect16("t1", 4'd8, 1'b0, 16'h8000);
        step();
        check("t1_pulse_end", 64'(bus16.o_valid), 64'd0);

        // Trailing one
        drive16(1'b1, 1'b1, 16'h0A30);
        step();
        drive16(1'b0, 1'b0, 16'h0000);
        step();
        step();
        expect16("t2", 4'd4, 1'b0, 16'h00A3);
        step();

        // Back-to-back samples with mixed modes
        drive16(1'b1, 1'b0, 16'h0000);
        step();
        drive16(1'b1, 1'b0, 16'hFFFF);
        step();
        drive16(1'b1, 1'b1, 16'h8000);
        step();
        drive16(1'b0, 1'b0, 16'h0000);
        expect16("t3_a", 4'd0, 1'b1, 16'h0000);
        step();
        expect16("t3_b", 4'd15, 1'b0, 16'hFFFF);
        step();
        expect16("t3_c", 4'd15, 1'b0, 16'h0001);
        step();
        check("t3_end", 64'(bus16.o_valid), 64'd0);

        // Clock-enable stall for 5 cycles mid-stream
        vcount = 0;
        drive16(1'b1, 1'b0, 16'h0001);
        step();
        vcount += int'(bus16.o_valid);
        drive16(1'b1, 1'b1, 16'h1234);
        step();
        vcount += int'(bus16.o_valid);
        drive16(1'b1, 1'b0, 16'h00F0);
        step();
        vcount += int'(bus16.o_valid);
        expect16("t4_s0", 4'd0, 1'b0, 16'h8000);
        aclken = 1'b0;
        drive16(1'b1, 1'b0, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            step();
            expect16("t4_frozen", 4'd0, 1'b0, 16'h8000);
        end
        aclken = 1'b1;
        drive16(1'b1, 1'b1, 16'h8001);
        step();
        vcount += int'(bus16.o_valid);
        expect16("t4_s1", 4'd2, 1'b0, 16'h048D);
        drive16(1'b0, 1'b0, 16'h0000);
        step();
        vcount += int'(bus16.o_valid);
        expect16("t4_s2", 4'd7, 1'b0, 16'hF000);
        step();
        vcount += int'(bus16.o_valid);
        expect16("t4_s3", 4'd0, 1'b0, 16'h8001);
        step();
        vcount += int'(bus16.o_valid);
        check("t4_vcount", 64'(vcount), 64'd4);

        // Asynchronous reset with samples in flight
        drive16(1'b1, 1'b0, 16'h0100);
        step();
        drive16(1'b1, 1'b1, 16'h0A30);
        step();
        drive16(1'b1, 1'b0, 16'hFFFF);
        step();
        drive16(1'b0, 1'b0, 16'h0000);
        check("t5_pre_valid", 64'(bus16.o_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(bus16.o_valid), 64'd0);
        check("t5_rst_loc",   64'(bus16.o_one_location), 64'd0);
        check("t5_rst_zero",  64'(bus16.o_zero), 64'd0);
        check("t5_rst_norm",  64'(bus16.o_norm_data), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_discard", 64'(bus16.o_valid), 64'd0);
        end
        drive16(1'b1, 1'b1, 16'h0001);
        step();
        drive16(1'b0, 1'b0, 16'h0000);
        step();
        check("t5_early", 64'(bus16.o_valid), 64'd0);
        step();
        expect16("t5_post", 4'd0, 1'b0, 16'h0001);
        step();

        // WIDTH=8, one level per stage: exhaustive sweep, LAT 4
        for (int i = 0; i < 512 + 3; i++) begin
            if (i < 512) begin
                bus8.i_valid = 1'b1;
                bus8.i_data  = i[7:0];
                bus8.i_mode  = i[8];
                s.d = 64'(i[7:0]);
                s.m = i[8];
                q8.push_back(s);
            end else begin
                bus8.i_valid = 1'b0;
            end
            step();
            if (i >= 3) begin
                s = q8.pop_front();
                model(s.d, s.m, 8, eloc, ez, enorm);
                check("w8_valid", 64'(bus8.o_valid), 64'd1);
                check("w8_loc",   64'(bus8.o_one_location), eloc);
                check("w8_zero",  64'(bus8.o_zero), 64'(ez));
                check("w8_norm",  64'(bus8.o_norm_data), enorm);
            end
        end
        step();
        check("w8_end", 64'(bus8.o_valid), 64'd0);

        // WIDTH=64, single search stage: random sweep, LAT 2
        for (int i = 0; i < 10000 + 1; i++) begin
            if (i < 10000) begin
                rd = {32'($urandom()), 32'($urandom())} >> $urandom_range(63, 0);
                if ($urandom_range(31, 0) == 0) rd = '0;
                rm = 1'($urandom_range(1, 0));
                bus64.i_valid = 1'b1;
                bus64.i_data  = rd;
                bus64.i_mode  = rm;
                s.d = rd;
                s.m = rm;
                q64.push_back(s);
            end else begin
                bus64.i_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                s = q64.pop_front();
                model(s.d, s.m, 64, eloc, ez, enorm);
                check("w64_valid", 64'(bus64.o_valid), 64'd1);
                check("w64_loc",   64'(bus64.o_one_location), eloc);
                check("w64_zero",  64'(bus64.o_zero), 64'(ez));
                check("w64_norm",  bus64.o_norm_data, enorm);
            end
        end
        step();
        check("w64_end", 64'(bus64.o_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
